// File: rtl/rev_counter_pkg.sv
// rev_counter_pkg: shared constants for the reversible counter and its
// terminal-count decoder.
package rev_counter_pkg;

   // Direction encoding on the s input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Default counter width.
   localparam int REV_CNT_W = 16;

   // Named view of the direction for code that prefers an enum.
   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } rev_dir_e;

endpackage : rev_counter_pkg

// File: rtl/rev_counter_tc.sv
// rev_counter_tc: combinational terminal-count decoder. Flags the last value
// before a wrap in the current direction: all-ones when counting up, zero
// when counting down. Kept separate so cascaded counters can reuse it.
module rev_counter_tc
   import rev_counter_pkg::*;
#(
   parameter int WIDTH = REV_CNT_W
)
(
   input  logic [WIDTH-1:0] cnt,
   input  logic             s,
   output logic             Rc
);

   logic all_ones;
   logic all_zero;

   // Reduction decodes of the count value.
   assign all_ones = &cnt;
   assign all_zero = ~(|cnt);

   // Select the decode that matches the live direction.
   always_comb begin
      Rc = 1'b0;
      if (s == DIR_UP) begin
         Rc = all_ones;
      end else begin
         Rc = all_zero;
      end
   end

endmodule : rev_counter_tc

// File: rtl/rev_counter.sv
// rev_counter: reversible (up/down) binary counter with ripple carry/borrow
// output for cascading. Counts on every rising clock edge; no enable, no load.
// Optional feature macro: REV_COUNTER_SAT_EN -- when defined the counter
// saturates at all-ones (up) and zero (down) instead of wrapping.
module rev_counter
   import rev_counter_pkg::*;
#(
   parameter int WIDTH = REV_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s,
   output logic [WIDTH-1:0] cnt,
   output logic             Rc
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             tc;

   // Terminal count is decoded from the registered value and the live s, so
   // a direction change is reflected on Rc without waiting for a clock edge.
   rev_counter_tc #(
      .WIDTH (WIDTH)
   ) u_tc (
      .cnt (cnt_q),
      .s   (s),
      .Rc  (tc)
   );

   // Next count: modular step in the selected direction, or hold at the
   // terminal value when saturation is built in.
   always_comb begin
      if (s == DIR_UP) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q - ONE;
      end
`ifdef REV_COUNTER_SAT_EN
      if (tc) begin
         cnt_d = cnt_q;
      end
`endif
   end

   // Count register; clears immediately on reset regardless of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign Rc  = tc;

endmodule : rev_counter

// File: tb/tb_rev_counter.sv
// tb_rev_counter: directed bench for rev_counter (WIDTH=16) with a behavioural
// reference count checked on every falling clock edge, plus literal checks.
`timescale 1ns/100ps
module tb_rev_counter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        s     = 1'b0;
   logic [15:0] cnt;
   logic        Rc;

   int vectors = 0;
   int miss    = 0;
   int m_cnt   = 0;   // reference count as a plain integer 0..65535

   rev_counter #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (s),
      .cnt   (cnt),
      .Rc    (Rc)
   );

   always #5 clk = ~clk;

   // Reference: plain modular (or clamped) arithmetic on an integer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_cnt <= 0;
`ifdef REV_COUNTER_SAT_EN
      else if (s)  m_cnt <= (m_cnt == 65535) ? 65535 : m_cnt + 1;
      else         m_cnt <= (m_cnt == 0) ? 0 : m_cnt - 1;
`else
      else if (s)  m_cnt <= (m_cnt + 1) % 65536;
      else         m_cnt <= (m_cnt + 65535) % 65536;
`endif
   end

   function automatic logic model_rc(input int c, input logic dir);
      return (dir && c == 65535) || (!dir && c == 0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the reference, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("model_cnt", {16'h0, cnt}, m_cnt[31:0]);
         chk("model_rc", {31'h0, Rc}, {31'h0, model_rc(m_cnt, s)});
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset asserted with no clock edge yet.
      #1 rst_n = 1'b0;
      #2 chk("rst_cnt", {16'h0, cnt}, 32'h0000);
      chk("rst_rc_down", {31'h0, Rc}, 32'h1);
      #1 s = 1'b1;
      #2 chk("rst_rc_up", {31'h0, Rc}, 32'h0);
      chk("rst_hold_cnt", {16'h0, cnt}, 32'h0000);
      #1 s = 1'b0;
      #5 rst_n = 1'b1;            // released at t=12, between edges

`ifndef REV_COUNTER_SAT_EN
      // Count down from reset.
      @(posedge clk); #1;
      chk("down_first", {16'h0, cnt}, 32'hFFFF);
      chk("down_first_rc", {31'h0, Rc}, 32'h0);
      repeat (99) @(posedge clk);
      #1 chk("down_100", {16'h0, cnt}, 32'hFF9C);
      // Switch to up: 100 edges bring FF9C back to 0 via FFFF.
      s = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (i == 98) chk("sw_fffe_rc", {31'h0, Rc}, 32'h0);
         if (i == 99) begin
            chk("sw_ffff", {16'h0, cnt}, 32'hFFFF);
            chk("sw_ffff_rc", {31'h0, Rc}, 32'h1);
         end
      end
      chk("sw_end", {16'h0, cnt}, 32'h0000);
      chk("sw_end_rc", {31'h0, Rc}, 32'h0);
      // Combinational Rc at zero, no clock edge.
      #1 s = 1'b0;
      #1 chk("comb_rc_down", {31'h0, Rc}, 32'h1);
      s = 1'b1;
      #1 chk("comb_rc_up", {31'h0, Rc}, 32'h0);
      // Step down to FFFE, then up through the wrap.
      s = 1'b0;
      @(posedge clk); #1 chk("dn_ffff", {16'h0, cnt}, 32'hFFFF);
      @(posedge clk); #1 chk("dn_fffe", {16'h0, cnt}, 32'hFFFE);
      s = 1'b1;
      @(posedge clk); #1;
      chk("up_ffff", {16'h0, cnt}, 32'hFFFF);
      chk("up_ffff_rc", {31'h0, Rc}, 32'h1);
      @(posedge clk); #1;
      chk("up_wrap", {16'h0, cnt}, 32'h0000);
      chk("up_wrap_rc", {31'h0, Rc}, 32'h0);
`else
      // Saturating: down from zero holds zero with Rc high.
      @(posedge clk); #1;
      chk("sat_down_first", {16'h0, cnt}, 32'h0000);
      chk("sat_down_rc", {31'h0, Rc}, 32'h1);
      repeat (2) @(posedge clk);
      #1 chk("sat_down_hold", {16'h0, cnt}, 32'h0000);
      s = 1'b1;
      #1 chk("comb_rc_up", {31'h0, Rc}, 32'h0);
      s = 1'b0;
      #1 chk("comb_rc_down", {31'h0, Rc}, 32'h1);
      s = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("sat_up5", {16'h0, cnt}, 32'h0005);
      chk("sat_up5_rc", {31'h0, Rc}, 32'h0);
      s = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("sat_back0", {16'h0, cnt}, 32'h0000);
      chk("sat_back0_rc", {31'h0, Rc}, 32'h1);
`endif

      // Count up to 0x1234 from zero, then reset between edges.
      s = 1'b1;
      repeat (16'h1234) @(posedge clk);
      #1 chk("mid_1234", {16'h0, cnt}, 32'h1234);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_cnt", {16'h0, cnt}, 32'h0000);
      chk("mid_rst_rc_up", {31'h0, Rc}, 32'h0);
      s = 1'b0;
      #1 chk("mid_rst_rc_down", {31'h0, Rc}, 32'h1);
      s = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1 chk("resume_1", {16'h0, cnt}, 32'h0001);
      repeat (3) @(posedge clk);
      #1 chk("resume_4", {16'h0, cnt}, 32'h0004);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule : tb_rev_counter
